matmul_stream_ctrl: RTL and testbench

MATMUL_STREAM_CTRL -- requirements
Module: matmul_stream_ctrl

---
 rtl/matmul_stream_ctrl.sv | 145 ++++++++++++++
 tb/tb_matmul_stream_ctrl.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_stream_ctrl.sv
// matmul_stream_ctrl: streams A/B operands into a matrix_mult,
// waits out its latency, then streams the captured product back out.
module matmul_stream_ctrl #(
  parameter int N     = 4,
  parameter int WIDTH = 16,
  parameter int LAT   = 6
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [WIDTH-1:0]                    in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [N-1:0][N-1:0][WIDTH-1:0]      mat_a,
  output logic [N-1:0][N-1:0][WIDTH-1:0]      mat_b,
  input  logic [N-1:0][N-1:0][2*WIDTH-1:0]    mat_c,
  output logic [2*WIDTH-1:0]                  out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_last,
  output logic                                busy
);

  localparam int NN = N * N;
  localparam int IW = $clog2(2 * NN + 1);
  localparam int CW = $clog2(LAT + 2);
  localparam int RW = 2 * WIDTH;

  localparam logic [IW-1:0] LAST_IN  = IW'(2 * NN - 1);
  localparam logic [IW-1:0] LAST_OUT = IW'(NN - 1);
  localparam logic [CW-1:0] WAIT_END = CW'(LAT);

  typedef enum logic [1:0] {
    S_LOAD,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t state;

  logic [IW-1:0] lidx;
  logic [IW-1:0] didx;
  logic [CW-1:0] wcnt;

  logic [N-1:0][N-1:0][RW-1:0] snap;
  logic [RW-1:0]               sel;

  logic in_hs;
  logic out_hs;
  logic cap;

  // Outputs are decoded from the registered state and
  // forced low while reset is held.
  assign in_ready  = ~rst & (state == S_LOAD);
  assign out_valid = ~rst & (state == S_DRAIN);
  assign out_last  = out_valid & (didx == LAST_OUT);
  assign busy      = ~rst & (state != S_LOAD);
  assign out_data  = out_valid ? sel : '0;

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;
  assign cap    = (state == S_WAIT) & (wcnt == WAIT_END);

  // Sequencer: LOAD -> WAIT (LAT+1 cycles) -> DRAIN -> LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_LOAD;
      lidx  <= '0;
      didx  <= '0;
      wcnt  <= '0;
    end else begin
      unique case (state)
        S_LOAD: begin
          if (in_hs) begin
            if (lidx == LAST_IN) begin
              lidx  <= '0;
              wcnt  <= '0;
              state <= S_WAIT;
            end else begin
              lidx <= lidx + IW'(1);
            end
          end
        end
        S_WAIT: begin
          if (wcnt == WAIT_END) begin
            wcnt  <= '0;
            didx  <= '0;
            state <= S_DRAIN;
          end else begin
            wcnt <= wcnt + CW'(1);
          end
        end
        S_DRAIN: begin
          if (out_hs) begin
            if (didx == LAST_OUT) begin
              didx  <= '0;
              state <= S_LOAD;
            end else begin
              didx <= didx + IW'(1);
            end
          end
        end
        default: begin
          state <= S_LOAD;
        end
      endcase
    end
  end

  // Operand registers: the load index picks one element of
  // A (first N*N) or B (next N*N), row-major.
  always_ff @(posedge clk) begin
    if (rst) begin
      mat_a <= '0;
      mat_b <= '0;
    end else if (in_hs) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (lidx == IW'(i * N + j))
            mat_a[i][j] <= in_data;
          if (lidx == IW'(NN + i * N + j))
            mat_b[i][j] <= in_data;
        end
      end
    end
  end

  // Product snapshot, taken once at the end of WAIT so later
  // mat_c activity cannot leak into the drained stream.
  always_ff @(posedge clk) begin
    if (rst)
      snap <= '0;
    else if (cap)
      snap <= mat_c;
  end

  // Row-major read mux over the snapshot.
  always_comb begin
    sel = '0;
    for (int k = 0; k < NN; k++) begin
      if (didx == IW'(k))
        sel = snap[k / N][k % N];
    end
  end

endmodule

// File: tb/tb_matmul_stream_ctrl.sv
// tb_matmul_stream_ctrl: scoreboard bench with a behavioural
// LAT-cycle matrix_mult attached to the controller.
module tb_matmul_stream_ctrl;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int W2  = 2 * W;
  localparam int LAT = 6;
  localparam int NN  = N * N;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [W-1:0]  in_data  = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W2-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic          busy;

  logic [N-1:0][N-1:0][W-1:0]  mat_a;
  logic [N-1:0][N-1:0][W-1:0]  mat_b;
  logic [N-1:0][N-1:0][W2-1:0] mat_c;
  logic [N-1:0][N-1:0][W2-1:0] prod;
  logic [N-1:0][N-1:0][W2-1:0] c_noise = '0;
  logic [N-1:0][N-1:0][W2-1:0] pipe [LAT];

  logic [W-1:0]  am [N][N];
  logic [W-1:0]  bm [N][N];
  logic [W2-1:0] exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  matmul_stream_ctrl #(
    .N(N), .WIDTH(W), .LAT(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mat_a(mat_a),
    .mat_b(mat_b),
    .mat_c(mat_c),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Attached matrix_mult: combinational product delayed LAT edges.
  always_comb begin
    prod = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        for (int k = 0; k < N; k++)
          prod[i][j] = prod[i][j] +
            W2'(mat_a[i][k]) * W2'(mat_b[k][j]);
  end

  always @(posedge clk) begin
    pipe[0] <= prod;
    for (int s = 1; s < LAT; s++)
      pipe[s] <= pipe[s-1];
  end

  assign mat_c = pipe[LAT-1] ^ c_noise;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic push_expected();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        logic [W2-1:0] s;
        s = '0;
        for (int k = 0; k < N; k++)
          s = s + W2'(am[i][k]) * W2'(bm[k][j]);
        exp_q.push_back(s);
      end
    end
  endtask

  task automatic rand_mats();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        am[i][j] = W'($urandom);
        bm[i][j] = W'($urandom);
      end
  endtask

  task automatic ident_mats();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        am[i][j] = W'(i + j);
        bm[i][j] = (i == j) ? W'(1) : W'(0);
      end
  endtask

  task automatic push_ident_seq();
    int seq [16] = '{0, 1, 2, 3, 1, 2, 3, 4,
                     2, 3, 4, 5, 3, 4, 5, 6};
    for (int k = 0; k < NN; k++)
      exp_q.push_back(W2'(seq[k]));
  endtask

  task automatic load_mats(input bit gaps);
    int k;
    int bound;
    bit hs;
    k = 0;
    bound = 0;
    while (k < 2 * NN && bound < 2000) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!in_valid)
        in_data = W'($urandom);
      else if (k < NN)
        in_data = am[k / N][k % N];
      else
        in_data = bm[(k - NN) / N][(k - NN) % N];
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) k++;
      bound++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (k !== 2 * NN) begin
      n_fail++;
      $display("FAIL load_count: got %0d required %0d", k, 2 * NN);
    end
  endtask

  task automatic drain(input int mode, input bit noise,
                       input bit garbage, input int stop_after);
    int got;
    int t;
    int bound;
    bit stall;
    bit rdy;
    logic [W2-1:0] hd;
    logic [W2-1:0] e;
    logic hl;
    got = 0;
    t = 0;
    bound = 0;
    stall = 0;
    while (out_valid !== 1'b1 && bound < 50) begin
      if (garbage) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data = W'($urandom);
      end
      @(posedge clk); #1;
      bound++;
    end
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_start: out_valid %b required 1", out_valid);
      in_valid = 1'b0;
      exp_q.delete();
      return;
    end
    if (noise)
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          c_noise[i][j] = W2'($urandom) | W2'(1);
    bound = 0;
    while (exp_q.size() > 0 && got < stop_after && bound < 500) begin
      if (garbage) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data = W'($urandom);
      end
      rdy = (mode == 0) ? 1'b1 : (t % 3 == 0);
      out_ready = rdy;
      if (stall) begin
        n_checks++;
        if (out_data !== hd || out_last !== hl || out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL hold: data %h last %b valid %b required %h %b 1",
                   out_data, out_last, out_valid, hd, hl);
        end
      end
      n_checks++;
      if (out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL out_valid_stream: got %b required 1", out_valid);
      end
      if (rdy) begin
        e = exp_q.pop_front();
        n_checks++;
        if (out_data !== e) begin
          n_fail++;
          $display("FAIL out_data[%0d]: got %h required %h", got, out_data, e);
        end
        n_checks++;
        if (out_last !== (exp_q.size() == 0)) begin
          n_fail++;
          $display("FAIL out_last[%0d]: got %b required %b",
                   got, out_last, exp_q.size() == 0);
        end
        got++;
        stall = 0;
      end else begin
        hd = out_data;
        hl = out_last;
        stall = 1;
      end
      @(posedge clk); #1;
      t++;
      bound++;
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    c_noise = '0;
    if (got == stop_after && exp_q.size() == 0) begin
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL after_last: in_ready %b out_valid %b busy %b required 1 0 0",
                 in_ready, out_valid, busy);
      end
    end else if (got != stop_after) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_count: got %0d required %0d", got, stop_after);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = '1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 ||
        busy !== 1'b0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy %b vld %b last %b busy %b data %h required 0",
               in_ready, out_valid, out_last, busy, out_data);
    end
    n_checks++;
    if (mat_a !== '0 || mat_b !== '0) begin
      n_fail++;
      $display("FAIL reset_mats: a %h b %h required 0", mat_a, mat_b);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: rdy %b busy %b vld %b required 1 0 0",
               in_ready, busy, out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_identity();
    ident_mats();
    push_ident_seq();
    load_mats(1'b0);
    n_checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL load_done: in_ready %b busy %b required 0 1", in_ready, busy);
    end
    for (int k = 1; k <= LAT + 1; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== (k == LAT + 1)) begin
        n_fail++;
        $display("FAIL latency E+%0d: out_valid %b required %b",
                 k, out_valid, k == LAT + 1);
      end
    end
    drain(0, 1'b0, 1'b0, NN);
  endtask

  task automatic test_backpressure();
    ident_mats();
    push_ident_seq();
    load_mats(1'b1);
    drain(1, 1'b1, 1'b0, NN);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        am[i][j] = 16'hFFFF;
        bm[i][j] = 16'hFFFF;
      end
    for (int k = 0; k < NN; k++)
      exp_q.push_back(32'hFFF80004);
    load_mats(1'b0);
    drain(0, 1'b0, 1'b0, NN);
  endtask

  task automatic test_reset_mid_drain();
    bit seen;
    rand_mats();
    push_expected();
    load_mats(1'b1);
    drain(0, 1'b0, 1'b0, 5);
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 ||
        in_ready !== 1'b0 || out_data !== '0 || mat_a !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: vld %b last %b busy %b rdy %b data %h required 0",
               out_valid, out_last, busy, in_ready, out_data);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_release: in_ready %b required 1", in_ready);
    end
    exp_q.delete();
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL no_partial_output: out_valid seen %b required 0", seen);
    end
    rand_mats();
    push_expected();
    load_mats(1'b0);
    drain(0, 1'b0, 1'b0, NN);
  endtask

  task automatic test_garbage();
    logic [N-1:0][N-1:0][W-1:0] ea;
    logic [N-1:0][N-1:0][W-1:0] eb;
    rand_mats();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ea[i][j] = am[i][j];
        eb[i][j] = bm[i][j];
      end
    push_expected();
    load_mats(1'b0);
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_data = W'($urandom);
      @(posedge clk); #1;
      n_checks++;
      if (mat_a !== ea || mat_b !== eb) begin
        n_fail++;
        $display("FAIL wait_garbage[%0d]: a %h b %h required %h %h",
                 c, mat_a, mat_b, ea, eb);
      end
    end
    drain(0, 1'b0, 1'b1, NN);
    n_checks++;
    if (mat_a !== ea || mat_b !== eb) begin
      n_fail++;
      $display("FAIL drain_garbage: a %h b %h required %h %h",
               mat_a, mat_b, ea, eb);
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 2; r++) begin
      rand_mats();
      push_expected();
      load_mats(1'b1);
      drain(r, 1'b0, 1'b0, NN);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_backpressure();
    test_overflow();
    test_reset_mid_drain();
    test_garbage();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
